// File: rtl/rgb_to_bayer_mosaic.sv
// rgb_to_bayer_mosaic: re-mosaics an RGB888 stream into 8-bit Bayer RAW with line-length
// checking and a frame counter; data, de and vs share a 2-cycle pipeline.
module rgb_to_bayer_mosaic #(
  parameter int          H_SIZE    = 1920,
  parameter int          V_SIZE    = 1080,
  parameter logic [1:0]  BAYER_PAT = 2'd0
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_rgb_vs,
  input  logic        I_rgb_de,
  input  logic [7:0]  I_rgb_r,
  input  logic [7:0]  I_rgb_g,
  input  logic [7:0]  I_rgb_b,
  output logic        O_raw_vs,
  output logic        O_raw_de,
  output logic [7:0]  O_raw_data,
  output logic        O_line_err,
  output logic [15:0] O_frame_cnt
);
  logic [13:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [7:0]  smp_s1_q, smp_d, raw_data_q;
  logic        vs_s1_q, de_s1_q, raw_vs_q, raw_de_q;
  logic        line_err_q, line_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]  p;
  logic        de_fall, vs_rise;
  // The stage-1 copies of vs/de double as the edge-detect history.
  always_comb begin
    de_fall     = de_s1_q & ~I_rgb_de;
    vs_rise     = I_rgb_vs & ~vs_s1_q;
    h_cnt_d     = !I_rgb_de ? '0 : (&h_cnt_q) ? h_cnt_q : h_cnt_q + 14'd1;
    v_cnt_d     = !I_rgb_vs ? '0 : !de_fall ? v_cnt_q :
                  (v_cnt_q == 11'(V_SIZE - 1)) ? '0 : v_cnt_q + 11'd1;
    p           = {v_cnt_q[0] ^ BAYER_PAT[1], h_cnt_q[0] ^ BAYER_PAT[0]};
    smp_d       = !I_rgb_de ? '0 : (p == 2'b01) ? I_rgb_r : (p == 2'b10) ? I_rgb_b : I_rgb_g;
    line_err_d  = (de_fall && h_cnt_q != 14'(H_SIZE)) ? 1'b1 : vs_rise ? 1'b0 : line_err_q;
    frame_cnt_d = frame_cnt_q + 16'(vs_rise);
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      smp_s1_q    <= '0;
      vs_s1_q     <= 1'b0;
      de_s1_q     <= 1'b0;
      raw_vs_q    <= 1'b0;
      raw_de_q    <= 1'b0;
      raw_data_q  <= '0;
      line_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      smp_s1_q    <= smp_d;
      vs_s1_q     <= I_rgb_vs;
      de_s1_q     <= I_rgb_de;
      raw_vs_q    <= vs_s1_q;
      raw_de_q    <= de_s1_q;
      raw_data_q  <= de_s1_q ? smp_s1_q : '0;
      line_err_q  <= line_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign O_raw_vs    = raw_vs_q;
  assign O_raw_de    = raw_de_q;
  assign O_raw_data  = raw_data_q;
  assign O_line_err  = line_err_q;
  assign O_frame_cnt = frame_cnt_q;
endmodule
